// File: rtl/mem_arb_pkg.sv
// Shared types and legal parameter ranges for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_BUSY = 2'd1,
        ACK     = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    localparam int READ_LAT_MIN   = 1;
    localparam int READ_LAT_MAX   = 4;
    localparam int MAX_STREAK_MIN = 1;
    localparam int MAX_STREAK_MAX = 15;

    // Counter widths sized for the largest legal parameter values.
    localparam int LAT_W    = 3;
    localparam int STREAK_W = 4;

    function automatic bit params_legal(input int read_lat, input int max_streak);
        return (read_lat >= READ_LAT_MIN) && (read_lat <= READ_LAT_MAX) &&
               (max_streak >= MAX_STREAK_MIN) && (max_streak <= MAX_STREAK_MAX);
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous RAM between instruction fetch and the memory stage.
// Data accesses win by default; a streak limit guarantees fetch progress.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 32,
    parameter int READ_LAT   = 2,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,

    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              dm_stall,

    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                if_valid_d, dm_valid_d;
    logic                capture;
    logic                grant_dm, grant_if;

    // Fetch only overrides a pending data request once the streak limit is reached.
    assign grant_dm = dm_req && !(if_req && (streak_q == STREAK_W'(MAX_STREAK)));
    assign grant_if = !grant_dm && if_req;

    assign if_stall = if_req & ~if_valid;
    assign dm_stall = dm_req & ~dm_valid;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
        state_d    = state_q;
        owner_d    = owner_q;
        lat_cnt_d  = lat_cnt_q;
        streak_d   = streak_q;
        addr_d     = addr_q;
        if_valid_d = 1'b0;
        dm_valid_d = 1'b0;
        capture    = 1'b0;
        ram_addr   = '0;
        ram_we     = 1'b0;
        ram_wdata  = dm_wdata;

        unique case (state_q)
            RD_BUSY: begin
                ram_addr  = addr_q;
                lat_cnt_d = lat_cnt_q + LAT_W'(1);
                if (lat_cnt_q == LAT_W'(READ_LAT)) begin
                    capture    = 1'b1;
                    lat_cnt_d  = '0;
                    state_d    = ACK;
                    if_valid_d = (owner_q == OWN_IF);
                    dm_valid_d = (owner_q == OWN_DM);
                end
            end
            // ACK has already raised valid through the register; it arbitrates like IDLE.
            IDLE, ACK: begin
                state_d = IDLE;
                if (grant_dm) begin
                    owner_d  = OWN_DM;
                    ram_addr = dm_addr;
                    ram_we   = dm_we;
                    addr_d   = dm_addr;
                    if (if_req) begin
                        streak_d = (streak_q == STREAK_W'(MAX_STREAK)) ? streak_q
                                                                      : streak_q + STREAK_W'(1);
                    end else begin
                        streak_d = '0;
                    end
                    if (dm_we) begin
                        state_d    = ACK;
                        dm_valid_d = 1'b1;
                    end else begin
                        state_d   = RD_BUSY;
                        lat_cnt_d = LAT_W'(1);
                    end
                end else if (grant_if) begin
                    owner_d   = OWN_IF;
                    ram_addr  = if_addr;
                    addr_d    = if_addr;
                    streak_d  = '0;
                    state_d   = RD_BUSY;
                    lat_cnt_d = LAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A write must never reach the RAM while reset is held.
        if (rst) begin
            ram_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_IF;
            lat_cnt_q <= '0;
            streak_q  <= '0;
            addr_q    <= '0;
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            lat_cnt_q <= lat_cnt_d;
            streak_q  <= streak_d;
            addr_q    <= addr_d;
            if_valid  <= if_valid_d;
            dm_valid  <= dm_valid_d;
            if (capture && owner_q == OWN_IF) begin
                if_rdata <= ram_rdata;
            end
            if (capture && owner_q == OWN_DM) begin
                dm_rdata <= ram_rdata;
            end
        end
    end

    param_range : assert property (@(posedge clk) params_legal(READ_LAT, MAX_STREAK));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed bench for mem_port_arbiter against a cycle-level transaction model.
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 11;
    localparam int DATA_W     = 32;
    localparam int READ_LAT   = 2;
    localparam int MAX_STREAK = 4;
    localparam int DEPTH      = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req, dm_req, dm_we;
    logic [ADDR_W-1:0] if_addr, dm_addr, ram_addr;
    logic [DATA_W-1:0] dm_wdata, if_rdata, dm_rdata, ram_wdata, ram_rdata;
    logic              if_valid, if_stall, dm_valid, dm_stall, ram_we;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT), .MAX_STREAK(MAX_STREAK)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Behavioural RAM with a READ_LAT-deep output pipeline and a bench-side load port.
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] ram [DEPTH];
    logic [DATA_W-1:0] rd_pipe [READ_LAT];

    always @(posedge clk) begin
        if (load_en) ram[load_addr] <= load_data;
        else if (ram_we) ram[ram_addr] <= ram_wdata;
        rd_pipe[0] <= ram[ram_addr];
        for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rdata = rd_pipe[READ_LAT-1];

    // Reference model: one outstanding transaction, completion cycle computed from the grant cycle.
    int                tests_run = 0;
    int                tests_failed = 0;
    int                cyc = 0;
    logic [DATA_W-1:0] ref_mem [DEPTH];
    bit                pend = 1'b0;
    bit                pend_dm, pend_read;
    int                pend_done;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_data;
    int                streak_m = 0;
    logic [DATA_W-1:0] exp_if_rdata = '0;
    logic [DATA_W-1:0] exp_dm_rdata = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Inputs for cycle cyc are already driven; checks that cycle and returns at the next negedge.
    task automatic step();
        bit exp_ifv, exp_dmv, free, gdm, gif;
        #1;
        exp_ifv = pend && (cyc == pend_done) && !pend_dm;
        exp_dmv = pend && (cyc == pend_done) && pend_dm;
        if (exp_ifv && pend_read) exp_if_rdata = pend_data;
        if (exp_dmv && pend_read) exp_dm_rdata = pend_data;
        check("if_valid", if_valid, exp_ifv);
        check("dm_valid", dm_valid, exp_dmv);
        check("if_rdata", if_rdata, exp_if_rdata);
        check("dm_rdata", dm_rdata, exp_dm_rdata);
        check("if_stall", if_stall, if_req & ~exp_ifv);
        check("dm_stall", dm_stall, dm_req & ~exp_dmv);
        free = !pend || (cyc == pend_done);
        if (rst) begin
            check("rst_ram_we", ram_we, 1'b0);
            pend = 1'b0;
            streak_m = 0;
            exp_if_rdata = '0;
            exp_dm_rdata = '0;
        end else if (free) begin
            gdm = dm_req && !(if_req && streak_m == MAX_STREAK);
            gif = !gdm && if_req;
            pend = gdm || gif;
            if (gdm) begin
                check("dm_ram_addr", ram_addr, dm_addr);
                check("dm_ram_we", ram_we, dm_we);
                pend_dm   = 1'b1;
                pend_read = !dm_we;
                pend_addr = dm_addr;
                pend_done = cyc + (dm_we ? 1 : READ_LAT + 1);
                if (dm_we) begin
                    check("ram_wdata", ram_wdata, dm_wdata);
                    ref_mem[dm_addr] = dm_wdata;
                end else begin
                    pend_data = ref_mem[dm_addr];
                end
                streak_m = if_req ? ((streak_m < MAX_STREAK) ? streak_m + 1 : MAX_STREAK) : 0;
            end else if (gif) begin
                check("if_ram_addr", ram_addr, if_addr);
                check("if_ram_we", ram_we, 1'b0);
                pend_dm   = 1'b0;
                pend_read = 1'b1;
                pend_addr = if_addr;
                pend_done = cyc + READ_LAT + 1;
                pend_data = ref_mem[if_addr];
                streak_m  = 0;
            end else begin
                check("idle_ram_addr", ram_addr, '0);
                check("idle_ram_we", ram_we, 1'b0);
            end
        end else begin
            check("busy_ram_addr", ram_addr, pend_addr);
            check("busy_ram_we", ram_we, 1'b0);
        end
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        logic [DATA_W-1:0] v;
        rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            v = (i == 'h010) ? 32'hE3A01005 : (i == 'h100) ? 32'hDEADBEEF : $urandom;
            load_en = 1'b1; load_addr = ADDR_W'(i); load_data = v; ref_mem[i] = v;
            @(negedge clk);
        end
        load_en = 1'b0;
        step();
        rst = 1'b0;

        // Lone fetch.
        if_req = 1'b1; if_addr = 11'h010;
        #1 check("t1_ram_addr", ram_addr, 11'h010);
        check("t1_if_stall", if_stall, 1'b1);
        step(); step(); step();
        #1 check("t1_if_valid", if_valid, 1'b1);
        check("t1_if_rdata", if_rdata, 32'hE3A01005);
        if_req = 1'b0;
        step();

        // Simultaneous fetch and load: data first.
        if_req = 1'b1; if_addr = 11'h020; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 11'h100;
        #1 check("t2_ram_addr_dm", ram_addr, 11'h100);
        step(); step(); step();
        #1 check("t2_dm_valid", dm_valid, 1'b1);
        check("t2_dm_rdata", dm_rdata, 32'hDEADBEEF);
        dm_req = 1'b0;
        #1 check("t2_ram_addr_if", ram_addr, 11'h020);
        step(); step(); step();
        #1 check("t2_if_valid", if_valid, 1'b1);
        check("t2_if_rdata", if_rdata, ref_mem['h020]);
        if_req = 1'b0;
        step();

        // Store then load of the same word.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 11'h104; dm_wdata = 32'h12345678;
        #1 check("t3_ram_we", ram_we, 1'b1);
        step();
        #1 check("t3_dm_valid_st", dm_valid, 1'b1);
        dm_we = 1'b0;
        #1 check("t3_ram_we_ld", ram_we, 1'b0);
        step(); step(); step();
        #1 check("t3_dm_valid_ld", dm_valid, 1'b1);
        check("t3_dm_rdata", dm_rdata, 32'h12345678);
        dm_req = 1'b0;
        step();

        // Streak limit: four data grants, then the waiting fetch.
        if_req = 1'b1; if_addr = 11'h030; dm_req = 1'b1; dm_we = 1'b1;
        for (int k = 0; k < 5; k++) begin
            dm_addr = 11'h200 + ADDR_W'(k); dm_wdata = $urandom;
            #1;
            if (k < 4) check("t4_data_grant", {ram_we, ram_addr}, {1'b1, dm_addr});
            else       check("t4_fetch_grant", {ram_we, ram_addr}, {1'b0, 11'h030});
            step();
        end
        step(); step();
        #1 check("t4_if_valid", if_valid, 1'b1);
        if_req = 1'b0;
        step();
        dm_req = 1'b0;
        step();

        // Reset while a read is in flight.
        if_req = 1'b1; if_addr = 11'h040;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; if_req = 1'b0; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 11'h100;
        #1 check("t5_if_valid", if_valid, 1'b0);
        check("t5_regrant", ram_addr, 11'h100);
        step();
        #1 check("t5_no_stale_valid", if_valid, 1'b0);
        step(); step();
        #1 check("t5_dm_valid", dm_valid, 1'b1);
        dm_req = 1'b0;
        step();

        // Fetch flushed after grant still completes, without a regrant.
        if_req = 1'b1; if_addr = 11'h050;
        step();
        if_req = 1'b0;
        step(); step();
        #1 check("t6_if_valid", if_valid, 1'b1);
        check("t6_if_rdata", if_rdata, ref_mem['h050]);
        check("t6_idle", {ram_we, ram_addr}, '0);
        step();

        // Random traffic with occasional flushes and resets.
        for (int n = 0; n < 4000; n++) begin
            if (if_req) begin
                if (if_valid) begin
                    if_req = ($urandom_range(0, 2) != 0);
                    if_addr = ADDR_W'($urandom_range(0, 63));
                end else if ($urandom_range(0, 31) == 0) begin
                    if_req = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = ADDR_W'($urandom_range(0, 63));
            end
            if (dm_req) begin
                if (dm_valid) begin
                    dm_req = ($urandom_range(0, 2) != 0);
                    dm_we = $urandom_range(0, 1); dm_addr = ADDR_W'($urandom_range(0, 63)); dm_wdata = $urandom;
                end else if ($urandom_range(0, 31) == 0) begin
                    dm_req = 1'b0;
                end
            end else if ($urandom_range(0, 1) == 0) begin
                dm_req = 1'b1;
                dm_we = $urandom_range(0, 1); dm_addr = ADDR_W'($urandom_range(0, 63)); dm_wdata = $urandom;
            end
            rst = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
